// File: rtl/alu_iterative_pkg.sv
// Shared opcodes, FSM state encoding and width defaults for the iterative ALU.
// ALU_ITERATIVE_MUL_EN adds the MUL opcode state to the encoding.
package alu_iterative_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;

  // Encodings match the upstream ALU control decoder.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef ALU_ITERATIVE_MUL_EN
    ST_DONE  = 2'd2,
    ST_MUL   = 2'd3
`else
    ST_DONE  = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/alu_iterative_shift.sv
// Bit-serial shifter for alu_iterative: accumulator, remaining-count and
// direction registers, loaded once at acceptance and stepped one position per cycle.
module alu_shift_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHAMT_WIDTH-1:0] i_amount,
  input  logic                   i_dir_left,
  output logic [DATA_WIDTH-1:0]  o_acc_next,
  output logic                   o_last
);

  logic [DATA_WIDTH-1:0]  r_acc;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_dir_left;

  assign o_acc_next = r_dir_left ? (r_acc << 1) : (r_acc >> 1);
  // The step taken while the count is 1 is the final one.
  assign o_last     = (r_cnt == SHAMT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_dir_left <= 1'b0;
    end else if (i_load) begin
      r_acc      <= i_data;
      r_cnt      <= i_amount;
      r_dir_left <= i_dir_left;
    end else if (i_step) begin
      r_acc <= o_acc_next;
      r_cnt <= r_cnt - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts under a
// start/busy/done handshake. Optional shift-add MUL with ALU_ITERATIVE_MUL_EN.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Handshake: start_i is taken on any rising edge where busy_o is low; done_o
  // pulses for one cycle when ALU_Result_o is final and the result then holds
  // until the next accepted start.
  state_e                  r_state, w_next_state;
  logic                    w_accept, w_shift_load, w_shift_step, w_shift_last;
  logic                    w_is_shift;
  logic [SHAMT_WIDTH-1:0]  w_amount;
  logic [DATA_WIDTH-1:0]   w_acc_next, w_comb_result, r_result;

  assign w_is_shift = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);
  assign w_amount   = B_i[SHAMT_WIDTH-1:0];

`ifdef ALU_ITERATIVE_MUL_EN
  logic [DATA_WIDTH-1:0]  r_mul_a, r_mul_b;
  logic [SHAMT_WIDTH:0]   r_mul_cnt;
  logic                   w_is_mul;
  assign w_is_mul = (ALU_Operation_i == OP_MUL);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_shift_load = 1'b0;
    w_shift_step = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_shift_step = 1'b1;
        if (w_shift_last) w_next_state = ST_DONE;
      end
`ifdef ALU_ITERATIVE_MUL_EN
      ST_MUL: begin
        if (r_mul_cnt == (SHAMT_WIDTH+1)'(1)) w_next_state = ST_DONE;
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
        if (start_i) begin
          w_accept = 1'b1;
          if (w_is_shift) begin
            w_shift_load = 1'b1;
            w_next_state = (w_amount == '0) ? ST_DONE : ST_SHIFT;
`ifdef ALU_ITERATIVE_MUL_EN
          end else if (w_is_mul) begin
            w_next_state = ST_MUL;
`endif
          end else begin
            w_next_state = ST_DONE;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_comb_result = '0;
    case (ALU_Operation_i)
      OP_ADD:  w_comb_result = A_i + B_i;
      OP_SUB:  w_comb_result = A_i - B_i;
      OP_AND:  w_comb_result = A_i & B_i;
      OP_OR:   w_comb_result = A_i | B_i;
      OP_XOR:  w_comb_result = A_i ^ B_i;
      OP_LUI:  w_comb_result = B_i;
      default: w_comb_result = '0;
    endcase
  end

  alu_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_shift_load),
    .i_step    (w_shift_step),
    .i_data    (A_i),
    .i_amount  (w_amount),
    .i_dir_left(ALU_Operation_i == OP_SLL),
    .o_acc_next(w_acc_next),
    .o_last    (w_shift_last)
  );

`ifdef ALU_ITERATIVE_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a   <= A_i;
      r_mul_b   <= B_i;
      r_mul_cnt <= (SHAMT_WIDTH+1)'(DATA_WIDTH);
    end else if (r_state == ST_MUL) begin
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= r_mul_cnt - (SHAMT_WIDTH+1)'(1);
    end
  end
`endif

  // The result register mirrors the shift accumulator while shifting and is
  // the partial-product sum while multiplying.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_accept) begin
      if (w_is_shift)     r_result <= A_i;
`ifdef ALU_ITERATIVE_MUL_EN
      else if (w_is_mul)  r_result <= '0;
`endif
      else                r_result <= w_comb_result;
    end else if (w_shift_step) begin
      r_result <= w_acc_next;
`ifdef ALU_ITERATIVE_MUL_EN
    end else if ((r_state == ST_MUL) && r_mul_b[0]) begin
      r_result <= r_result + r_mul_a;
`endif
    end
  end

  assign ALU_Result_o = r_result;
  assign Zero_o       = (r_result == '0);
  assign done_o       = (r_state == ST_DONE);
`ifdef ALU_ITERATIVE_MUL_EN
  assign busy_o       = (r_state == ST_SHIFT) || (r_state == ST_MUL);
`else
  assign busy_o       = (r_state == ST_SHIFT);
`endif

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative: vector table for latency and
// results, plus hand sequences for reset abort, back-to-back and ignored starts.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i, B_i;
  logic [31:0] ALU_Result_o;
  logic        Zero_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  alu_iterative dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(ALU_Operation_i),
    .A_i            (A_i),
    .B_i            (B_i),
    .ALU_Result_o   (ALU_Result_o),
    .Zero_o         (Zero_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start; returns at #1 after the accepting edge (cycle N+1).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Bounded wait for done_o; lat counts cycles since acceptance.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat = lat0;
    busy_cnt = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", lat);
    end
  endtask

  initial begin
    int lat, busy_cnt, done_seen;
    logic [31:0] held;

    vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[1]  = '{4'b0000, 32'd3,         32'd4,         32'd7,         1};
    vecs[2]  = '{4'b0001, 32'd5,         32'd7,         32'hFFFF_FFFE, 1};
    vecs[3]  = '{4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1};
    vecs[4]  = '{4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1};
    vecs[5]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1};
    vecs[6]  = '{4'b0101, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1};
    vecs[7]  = '{4'b0111, 32'h0000_0001, 32'd31,        32'h8000_0000, 32};
    vecs[8]  = '{4'b0110, 32'h8000_0000, 32'd0,         32'h8000_0000, 1};
    vecs[9]  = '{4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000, 5};
    vecs[10] = '{4'b0111, 32'h0000_00F1, 32'h0000_0024, 32'h0000_0F10, 5};
    vecs[11] = '{4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1};
`ifdef ALU_ITERATIVE_MUL_EN
    vecs[12] = '{4'b1000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33};
`else
    vecs[12] = '{4'b1000, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 1};
`endif

    reset = 1'b1;
    start_i = 1'b0;
    ALU_Operation_i = 4'b0000;
    A_i = '0;
    B_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", ALU_Result_o, 32'h0);
    check("reset_zero",   {31'b0, Zero_o}, 32'h1);
    check("reset_busy",   {31'b0, busy_o}, 32'h0);
    check("reset_done",   {31'b0, done_o}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat, busy_cnt);
      check($sformatf("v%0d_result", i), ALU_Result_o, vecs[i].exp);
      check($sformatf("v%0d_zero", i), {31'b0, Zero_o}, {31'b0, (vecs[i].exp == 32'h0)});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].lat - 1);
      held = ALU_Result_o;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_drop", i), {31'b0, done_o}, 32'h0);
      check($sformatf("v%0d_hold", i), ALU_Result_o, held);
    end

    // Start issued during the DONE cycle is accepted.
    issue(4'b0111, 32'd3, 32'd2);
    wait_done(1, lat, busy_cnt);
    check("b2b_first", ALU_Result_o, 32'd12);
    ALU_Operation_i = 4'b0000;
    A_i = 32'd10;
    B_i = 32'd20;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("b2b_done", {31'b0, done_o}, 32'h1);
    check("b2b_result", ALU_Result_o, 32'd30);

    // Start pulsed while busy is ignored.
    issue(4'b0111, 32'd1, 32'd10);
    @(posedge clk);
    #1;
    check("ign_busy", {31'b0, busy_o}, 32'h1);
    ALU_Operation_i = 4'b0000;
    A_i = 32'd0;
    B_i = 32'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(3, lat, busy_cnt);
    check("ign_latency", lat, 11);
    check("ign_result", ALU_Result_o, 32'h0000_0400);

    // Reset during a shift aborts with no done pulse.
    issue(4'b0111, 32'd1, 32'd20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_result", ALU_Result_o, 32'h0);
    check("abort_zero",   {31'b0, Zero_o}, 32'h1);
    check("abort_busy",   {31'b0, busy_o}, 32'h0);
    check("abort_done",   {31'b0, done_o}, 32'h0);
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) done_seen++;
    end
    check("abort_quiet", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code, operand A (rs1) and operand B (rs2 or immediate).
- Produces a registered result and a zero flag.
- Logic ops complete in one cycle. Shifts run bit-serially, one position per cycle, under a start/done handshake, so the core stalls on busy_o.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount field width; equals log2(DATA_WIDTH).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request to execute the operation presented this cycle.
- ALU_Operation_i  input  4  operation code from the ALU control decoder.
- A_i  input  DATA_WIDTH  operand A.
- B_i  input  DATA_WIDTH  operand B; bits [SHAMT_WIDTH-1:0] are the shift amount for shifts.
- ALU_Result_o  output  DATA_WIDTH  registered result.
- Zero_o  output  1  high when ALU_Result_o == 0.
- busy_o  output  1  operation in progress; start_i is ignored while high.
- done_o  output  1  one-cycle pulse when ALU_Result_o is final.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE, ALU_Result_o = 0, Zero_o = 1, busy_o = 0, done_o = 0, shift counter = 0.
- Reset mid-operation aborts immediately. No done_o pulse is produced for the aborted operation.
- Opcodes:
  - 0000 ADD: A+B, mod 2^DATA_WIDTH.
  - 0001 SUB: A-B, mod 2^DATA_WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 LUI: result = B_i unmodified; the immediate arrives already positioned.
  - 0110 SRL: logical shift right by B_i[4:0].
  - 0111 SLL: logical shift left by B_i[4:0].
  - Any other code: result 0, single-cycle.
- States: IDLE, SHIFT, DONE.
- start_i is accepted in IDLE or DONE, i.e. whenever busy_o = 0. This allows back-to-back operations.
- Non-shift op accepted in cycle N:
  - Result registered at the end of N; state goes to DONE.
  - done_o = 1 and the result is valid in cycle N+1 (latency 1).
- Shift with amount k accepted in cycle N:
  - At the end of N, accumulator = A_i, counter = k, direction latched.
  - If k = 0, go to DONE. Otherwise go to SHIFT.
- SHIFT state, each cycle:
  - Shift accumulator by 1 (zero fill) and decrement counter.
  - When counter goes 1→0, go to DONE.
  - done_o is therefore asserted in cycle N+1+k. Maximum latency is 32 cycles (k = 31).
- busy_o = 1 exactly while state == SHIFT.
- done_o = 1 exactly while state == DONE.
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted.
- ALU_Result_o is held stable from done until the next accepted start.
- During SHIFT, ALU_Result_o shows the partial accumulator and is not meaningful until done_o.
- Zero_o is derived from the registered result in the same cycle as ALU_Result_o.
- While busy, operand and opcode inputs are don't-care. They are latched only at acceptance.

Optional Feature:
- Macro: ALU_ITERATIVE_MUL_EN.
- When defined:
  - Opcode 1000 is MUL, returning the low DATA_WIDTH bits of A×B.
  - Implemented as shift-add in a fourth state MUL, one multiplier bit per cycle.
  - Runs DATA_WIDTH iterations; done_o in cycle N+1+DATA_WIDTH.
  - busy_o is high in MUL.
- When undefined: 1000 falls into the default case (result 0, latency 1) and no MUL state or multiplier registers exist.

Decomposition:
- Shared package holds:
  - the 4-bit opcode constants (ADD…SLL, MUL), identical to the ALU control decoder encodings;
  - the state encoding;
  - DATA_WIDTH/SHAMT_WIDTH defaults.
- One natural sub-module, alu_shift_unit, containing the accumulator, counter and direction register. It takes load/step inputs and reports last-step.
- The top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan:
- Reset values: assert reset during a shift, release → outputs 0/1/0/0, state IDLE, no done pulse.
- ADD overflow: start ADD, A=0xFFFFFFFF, B=1 → cycle N+1: result 0x00000000, Zero_o=1, done_o=1.
- SUB / XOR: SUB A=5, B=7 → 0xFFFFFFFE. XOR A=0xF0F0F0F0, B=0xFFFF0000 → 0x0F0FF0F0. Each with done at N+1.
- Shift latency and back-to-back:
  - SLL A=1, B=31 → busy_o high 31 cycles, done at N+32, result 0x80000000.
  - SRL A=0x80000000, B=0 → done at N+1, result 0x80000000.
  - A start issued in the DONE cycle is accepted.
- Ignored starts and undefined opcodes: pulse start_i with different operands while busy → ignored, original result unchanged. Opcode 1111 → result 0, done at N+1.
- ALU_ITERATIVE_MUL_EN:
  - Defined: MUL A=0x10001, B=0x10001 → result 0x00020001 at N+33.
  - Undefined: same stimulus → result 0 at N+1.
